fp_mul_norm_round: RTL and testbench

//  Post-multiply stage of the FPU single-precision multiply path. Consumes the raw
//  2*MANT_WIDTH-bit mantissa product from the radix-16 mantissa multiplier, plus the
//  pre-computed biased exponent sum and result sign. Normalizes, rounds and applies

---
 rtl/fp_mul_norm_round.sv | 228 ++++++++++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
// Post-multiply normalize/round/pack stage of the single-precision FPU multiply path.
// Define FPU_ROUND_MODE_EN to add a roundMode input (RNE/RTZ/RUP/RDN); otherwise RNE only.

module fp_mul_norm_round #(
    parameter int unsigned MANT_WIDTH = 24,
    parameter int unsigned EXP_WIDTH  = 8,
    localparam int unsigned PROD_WIDTH = 2 * MANT_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [PROD_WIDTH-1:0]           prodIn,
    input  logic [EXP_WIDTH+1:0]            expIn,
    input  logic                            signIn,
`ifdef FPU_ROUND_MODE_EN
    input  logic [1:0]                      roundMode,
`endif
    input  logic                            inValid,
    output logic                            inReady,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] result,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            inexact,
    output logic                            outValid,
    input  logic                            outReady
);

    localparam int unsigned XW = EXP_WIDTH + 2;
    localparam int unsigned RW = EXP_WIDTH + MANT_WIDTH;

    localparam logic signed [XW-1:0] ExpOne    = XW'(1);
    localparam logic signed [XW-1:0] ExpZero   = '0;
    localparam logic signed [XW-1:0] ExpInf    = XW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [XW-1:0] ExpPosMax = {1'b0, {(XW-1){1'b1}}};

    typedef enum logic [1:0] {
        NR_IDLE,
        NR_NORM,
        NR_ROUND,
        NR_OUT
    } state_e;

    state_e state_q, state_d;

    // Input capture
    logic [PROD_WIDTH-1:0] prod_q;
    logic signed [XW-1:0]  exp_in_q;
    logic                  sign_q;

    // Normalized operand
    logic [MANT_WIDTH-1:0] mant_q;
    logic signed [XW-1:0]  exp_q;
    logic                  guard_q;
    logic                  sticky_q;
    logic                  zero_q;

    // Output holding registers
    logic [RW-1:0] result_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          inexact_q;

    logic accept;

    // Exponent increments saturate rather than wrap into the negative range.
    function automatic logic signed [XW-1:0] exp_inc(input logic signed [XW-1:0] e);
        return (e == ExpPosMax) ? e : e + ExpOne;
    endfunction

    assign accept   = inValid && (state_q == NR_IDLE);
    assign inReady  = (state_q == NR_IDLE);
    assign outValid = (state_q == NR_OUT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NR_IDLE:  if (inValid) state_d = NR_NORM;
            NR_NORM:  state_d = NR_ROUND;
            NR_ROUND: state_d = NR_OUT;
            NR_OUT:   if (outReady) state_d = NR_IDLE;
            default:  state_d = NR_IDLE;
        endcase
    end

    // Normalization
    logic [PROD_WIDTH-1:0] norm_shift;
    logic [MANT_WIDTH-1:0] norm_mant;
    logic                  norm_guard;
    logic                  norm_sticky;
    logic signed [XW-1:0]  norm_exp;
    logic                  norm_zero;

    always_comb begin
        norm_shift  = prod_q[PROD_WIDTH-1] ? prod_q : {prod_q[PROD_WIDTH-2:0], 1'b0};
        norm_mant   = norm_shift[PROD_WIDTH-1 -: MANT_WIDTH];
        norm_guard  = norm_shift[PROD_WIDTH-MANT_WIDTH-1];
        norm_sticky = |norm_shift[PROD_WIDTH-MANT_WIDTH-2:0];
        norm_exp    = prod_q[PROD_WIDTH-1] ? exp_inc(exp_in_q) : exp_in_q;
        norm_zero   = (prod_q == '0);
    end

`ifdef FPU_ROUND_MODE_EN
    localparam logic [1:0] RmRne = 2'b00;
    localparam logic [1:0] RmRtz = 2'b01;
    localparam logic [1:0] RmRup = 2'b10;
    localparam logic [1:0] RmRdn = 2'b11;

    logic [1:0] mode_q;
`endif

    // Rounding and packing
    logic                  rnd_up;
    logic [MANT_WIDTH:0]   mant_sum;
    logic [MANT_WIDTH-2:0] rnd_frac;
    logic signed [XW-1:0]  rnd_exp;
    logic                  sat_to_max;
    logic [RW-1:0]         pack_result;
    logic                  pack_ovf;
    logic                  pack_unf;
    logic                  pack_inx;

    always_comb begin
        rnd_up     = guard_q & (sticky_q | mant_q[0]);
        sat_to_max = 1'b0;
`ifdef FPU_ROUND_MODE_EN
        unique case (mode_q)
            RmRne: rnd_up = guard_q & (sticky_q | mant_q[0]);
            RmRtz: rnd_up = 1'b0;
            RmRup: rnd_up = (guard_q | sticky_q) & ~sign_q;
            RmRdn: rnd_up = (guard_q | sticky_q) & sign_q;
            default: rnd_up = guard_q & (sticky_q | mant_q[0]);
        endcase
        sat_to_max = (mode_q == RmRtz) || ((mode_q == RmRup) && sign_q) ||
                     ((mode_q == RmRdn) && !sign_q);
`endif
        mant_sum = {1'b0, mant_q} + {{MANT_WIDTH{1'b0}}, rnd_up};
        if (mant_sum[MANT_WIDTH]) begin
            rnd_frac = mant_sum[MANT_WIDTH-1:1];
            rnd_exp  = exp_inc(exp_q);
        end else begin
            rnd_frac = mant_sum[MANT_WIDTH-2:0];
            rnd_exp  = exp_q;
        end

        pack_result = {sign_q, rnd_exp[EXP_WIDTH-1:0], rnd_frac};
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        pack_inx    = guard_q | sticky_q;
        if (zero_q) begin
            pack_result = {sign_q, {(RW-1){1'b0}}};
            pack_inx    = 1'b0;
        end else if (rnd_exp >= ExpInf) begin
            pack_ovf = 1'b1;
            pack_inx = 1'b1;
            if (sat_to_max) begin
                pack_result = {sign_q, {(EXP_WIDTH-1){1'b1}}, 1'b0, {(MANT_WIDTH-1){1'b1}}};
            end else begin
                pack_result = {sign_q, {EXP_WIDTH{1'b1}}, {(MANT_WIDTH-1){1'b0}}};
            end
        end else if (rnd_exp <= ExpZero) begin
            pack_result = {sign_q, {(RW-1){1'b0}}};
            pack_unf    = 1'b1;
            pack_inx    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= NR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q   <= '0;
            exp_in_q <= '0;
            sign_q   <= 1'b0;
`ifdef FPU_ROUND_MODE_EN
            mode_q   <= RmRne;
`endif
        end else if (accept) begin
            prod_q   <= prodIn;
            exp_in_q <= expIn;
            sign_q   <= signIn;
`ifdef FPU_ROUND_MODE_EN
            mode_q   <= roundMode;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mant_q   <= '0;
            exp_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state_q == NR_NORM) begin
            mant_q   <= norm_mant;
            exp_q    <= norm_exp;
            guard_q  <= norm_guard;
            sticky_q <= norm_sticky;
            zero_q   <= norm_zero;
        end
    end

    // Outputs are loaded on entry to NR_OUT and held there until drained.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else if (state_q == NR_ROUND) begin
            result_q    <= pack_result;
            overflow_q  <= pack_ovf;
            underflow_q <= pack_unf;
            inexact_q   <= pack_inx;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.

module tb_fp_mul_norm_round;

    logic        clock;
    logic        reset;
    logic [47:0] prodIn;
    logic [9:0]  expIn;
    logic        signIn;
    logic [1:0]  roundMode;
    logic        inValid;
    logic        inReady;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic        outValid;
    logic        outReady;

    int n_pass  = 0;
    int n_total = 0;

    fp_mul_norm_round dut (
        .clock     (clock),
        .reset     (reset),
        .prodIn    (prodIn),
        .expIn     (expIn),
        .signIn    (signIn),
`ifdef FPU_ROUND_MODE_EN
        .roundMode (roundMode),
`endif
        .inValid   (inValid),
        .inReady   (inReady),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact),
        .outValid  (outValid),
        .outReady  (outReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [47:0] prod;
        logic [9:0]  expv;
        logic        sign;
        logic [1:0]  mode;
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, inexact}
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [47:0] p, input logic [9:0] e, input logic s,
                           input logic [1:0] m, input logic [31:0] r, input logic [2:0] f);
        vec_t v;
        v.prod = p; v.expv = e; v.sign = s; v.mode = m; v.res = r; v.flags = f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: value P of the product, split into kept mantissa and discarded remainder.
    function automatic void model(input logic [47:0] p, input int e, input bit s,
                                  input int mode, output logic [31:0] r,
                                  output logic [2:0] f);
        longint unsigned pv, m, rem, half;
        int  ex;
        bit  up, ix;
        pv = 64'(p);
        if (pv == 0) begin
            r = {s, 31'b0};
            f = 3'b000;
            return;
        end
        if (pv >= (64'd1 << 47)) begin
            ex = e + 1; m = pv >> 24; rem = pv % (64'd1 << 24); half = 64'd1 << 23;
        end else begin
            ex = e;     m = pv >> 23; rem = pv % (64'd1 << 23); half = 64'd1 << 22;
        end
        ix = (rem != 0);
        case (mode)
            1:       up = 1'b0;
            2:       up = ix && !s;
            3:       up = ix && s;
            default: up = (rem > half) || ((rem == half) && (m % 2 == 1));
        endcase
        m = m + 64'(up);
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) begin
            if (mode == 1 || (mode == 2 && s) || (mode == 3 && !s)) r = {s, 8'hFE, 23'h7FFFFF};
            else r = {s, 8'hFF, 23'h0};
            f = 3'b101;
        end else if (ex <= 0) begin
            r = {s, 31'b0};
            f = 3'b011;
        end else begin
            r = {s, ex[7:0], m[22:0]};
            f = {2'b00, ix};
        end
    endfunction

    // One full transaction; lat counts rising edges from the accept edge (inclusive)
    // up to the one after which outValid is first seen.
    task automatic run_op(input logic [47:0] p, input logic [9:0] e, input logic s,
                          input logic [1:0] m, output logic [31:0] r,
                          output logic [2:0] f, output int lat);
        int n;
        @(negedge clock);
        prodIn = p; expIn = e; signIn = s; roundMode = m; inValid = 1'b1; outReady = 1'b0;
        n = 0;
        while (!inReady && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("accept_ready", 64'(inReady), 64'd1);
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        inValid = 1'b0;
        prodIn  = {$urandom, $urandom} >> 16;
        expIn   = 10'($urandom);
        signIn  = ~s;
        while (!outValid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        r = result;
        f = {overflow, underflow, inexact};
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
    endtask

    initial begin
        logic [31:0] r, r0;
        logic [2:0]  f, ef;
        logic [31:0] er;
        logic [47:0] p;
        int          lat, ev, md, n;
        bit          seen;

        reset = 1'b1; prodIn = '0; expIn = '0; signIn = 1'b0; roundMode = 2'b00;
        inValid = 1'b0; outReady = 1'b0;

        // Directed vectors
        add_vec(48'h9000_0000_0000, 10'd127, 1'b0, 2'd0, 32'h4010_0000, 3'b000);
        add_vec(48'h4000_0000_0000, 10'd127, 1'b1, 2'd0, 32'hBF80_0000, 3'b000);
        add_vec(48'h4000_00C0_0000, 10'd127, 1'b0, 2'd0, 32'h3F80_0002, 3'b001);
        add_vec(48'h7FFF_FFC0_0000, 10'd127, 1'b0, 2'd0, 32'h4000_0000, 3'b001);
        add_vec(48'h8000_0000_0000, 10'd254, 1'b0, 2'd0, 32'h7F80_0000, 3'b101);
        add_vec(48'h4000_0000_0000, 10'd0,   1'b1, 2'd0, 32'h8000_0000, 3'b011);
        add_vec(48'h0000_0000_0000, 10'd127, 1'b0, 2'd0, 32'h0000_0000, 3'b000);
        add_vec(48'h4000_0000_0000, 10'd254, 1'b0, 2'd0, 32'h7F00_0000, 3'b000);
        add_vec(48'h4000_0000_0000, 10'd1,   1'b0, 2'd0, 32'h0080_0000, 3'b000);
        add_vec(48'h7FFF_FFC0_0000, 10'd254, 1'b1, 2'd0, 32'hFF80_0000, 3'b101);
        add_vec(48'h4000_0000_0001, 10'd127, 1'b0, 2'd0, 32'h3F80_0000, 3'b001);
        add_vec(48'h4000_0040_0000, 10'd127, 1'b0, 2'd0, 32'h3F80_0000, 3'b001);
`ifdef FPU_ROUND_MODE_EN
        add_vec(48'h4000_00C0_0000, 10'd127, 1'b0, 2'd1, 32'h3F80_0001, 3'b001);
        add_vec(48'h4000_0000_0001, 10'd127, 1'b0, 2'd2, 32'h3F80_0001, 3'b001);
        add_vec(48'h4000_0000_0001, 10'd127, 1'b1, 2'd3, 32'hBF80_0001, 3'b001);
        add_vec(48'h8000_0000_0000, 10'd254, 1'b0, 2'd1, 32'h7F7F_FFFF, 3'b101);
        add_vec(48'h8000_0000_0000, 10'd254, 1'b1, 2'd2, 32'hFF7F_FFFF, 3'b101);
`endif

        repeat (3) @(negedge clock);
        check("reset_state", {58'd0, inReady, outValid, overflow, underflow, inexact, 1'b0},
              {58'd0, 6'b100000});
        check("reset_result", 64'(result), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].prod, vecs[i].expv, vecs[i].sign, vecs[i].mode, r, f, lat);
            check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
            check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].flags));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        end

        // Backpressure with a second op waiting on inValid
        @(negedge clock);
        prodIn = 48'h9000_0000_0000; expIn = 10'd127; signIn = 1'b0; inValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        prodIn = 48'h4000_0000_0000; expIn = 10'd127; signIn = 1'b1;
        n = 0;
        while (!outValid && n < 12) begin
            @(negedge clock);
            n++;
        end
        check("bp_valid", 64'(outValid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d", k), {29'd0, outValid, inReady, 1'b0, result},
                  {29'd0, 2'b10, 1'b0, 32'h4010_0000});
        end
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
        check("bp_drain", {62'd0, outValid, inReady}, {62'd0, 2'b01});
        @(negedge clock);
        inValid = 1'b0;
        check("bp_second_accepted", 64'(inReady), 64'd0);
        lat = 1;
        while (!outValid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check("bp_second_latency", 64'(lat), 64'd3);
        check("bp_second_result", 64'(result), 64'hBF80_0000);
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;

        // Reset while the op sits in the rounding state
        @(negedge clock);
        prodIn = 48'h9000_0000_0000; expIn = 10'd127; signIn = 1'b0; inValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_outvalid", 64'(outValid), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_inready", 64'(inReady), 64'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (outValid) seen = 1'b1;
        end
        check("rst_no_spurious", 64'(seen), 64'd0);

        // Randomized operations against the model
        for (int k = 0; k < 150; k++) begin
            p[31:0]  = $urandom;
            p[47:32] = 16'($urandom);
            p[47:46] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) p[22:0] = 23'h40_0000;
            if ($urandom_range(0, 7) == 0) p[46:23] = 24'hFF_FFFF;
            ev = int'($urandom_range(0, 340)) - 40;
`ifdef FPU_ROUND_MODE_EN
            md = int'($urandom_range(0, 3));
`else
            md = 0;
`endif
            r0 = 32'($urandom);
            model(p, ev, r0[0], md, er, ef);
            run_op(p, 10'(ev), r0[0], 2'(md), r, f, lat);
            check($sformatf("rand%0d_out", k), {29'd0, f, r}, {29'd0, ef, er});
            check($sformatf("rand%0d_latency", k), 64'(lat), 64'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
